zeroriscy_dmem_arbiter: RTL and testbench
=========================================

Name: zeroriscy_dmem_arbiter

Overview:
Shares the single-port data SRAM (dmem) between the zero-riscy core LSU port and a host/loader port. Uses the core's req/gnt/rvalid protocol on both sides. Also decodes two MMIO addresses: the tohost word, which gives sticky pass/fail status, and the console byte register, which emits a character strobe. Sits between zeroriscy_core, the host port and zeroriscy_d_sram inside zeroriscy_sim_top.

Parameters:
MEM_AW, 15, dmem word-address width (dmem depth = 2**MEM_AW words)
DMEM_BASE, 32'h80000000, byte base of dmem window; must be aligned to 2**(MEM_AW+2)
TOHOST_ADDR, 32'h80001000, tohost MMIO word address; takes priority over the dmem window
CONSOLE_ADDR, 32'h9a100000, console MMIO word address

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
c_req_i / h_req_i  in  1  core / host request
c_we_i / h_we_i  in  1  write enable
c_be_i / h_be_i  in  4  byte enables
c_addr_i / h_addr_i  in  32  byte address (bits [1:0] ignored)
c_wdata_i / h_wdata_i  in  32  write data
c_gnt_o / h_gnt_o  out  1  grant, combinational in the request cycle
c_rvalid_o / h_rvalid_o  out  1  response valid
c_rdata_o / h_rdata_o  out  32  read data, valid with rvalid
c_err_o / h_err_o  out  1  decode error, valid with rvalid
mem_req_o  out  1  SRAM access
mem_we_o  out  1  SRAM write
mem_be_o  out  4  SRAM byte enables
mem_addr_o  out  MEM_AW  SRAM word address
mem_wdata_o  out  32  SRAM write data
mem_rdata_i  in  32  SRAM read data, one cycle after mem_req_o
tohost_valid_o  out  1  one-cycle pulse on a tohost write
tohost_data_o  out  32  last tohost write data
sim_done_o  out  1  sticky: a nonzero tohost value has been written
sim_pass_o  out  1  sticky: that first nonzero value was 1
console_valid_o  out  1  one-cycle pulse on a console write with be[0]=1
console_char_o  out  8  character, wdata[7:0]

Behaviour:
- Reset: all outputs 0; round-robin pointer last_grant=HOST, so the core wins the first conflict. A response pending at reset is dropped (no rvalid).
- Arbitration is combinational in cycle t.
  - One requester active: it is granted.
  - Both active: the one not equal to last_grant is granted; last_grant updates at the edge.
  - At most one gnt per cycle. The loser holds req/addr/wdata stable until granted.
  - No starvation: under continuous contention grants strictly alternate C,H,C,H.
- Decode of the granted address, word compare on addr[31:2]:
  - TOHOST: addr==TOHOST_ADDR.
  - CONSOLE: addr==CONSOLE_ADDR.
  - DMEM: addr[31:MEM_AW+2]==DMEM_BASE[31:MEM_AW+2], and the address is not TOHOST.
  - ERR: any other address.
- DMEM grant: mem_req_o=1 in cycle t; mem_we/be/wdata are passed through; mem_addr_o=addr[MEM_AW+1:2].
- Any other decode: mem_req_o=0.
- Response:
  - Granted requester sees rvalid=1 in cycle t+1, exactly one cycle, for reads and writes alike.
  - DMEM read: rdata=mem_rdata_i.
  - Other reads: rdata=0.
  - err=1 only for ERR.
  - The non-granted rvalid stays 0.
- Back-to-back: a new grant in t+1 is legal while the t response is delivered; full throughput is 1 access/cycle.
- TOHOST write:
  - In t+1: tohost_valid_o=1 and tohost_data_o=wdata.
  - If !sim_done_o and wdata!=0: sim_done_o<=1 and sim_pass_o<=(wdata==1); both hold until reset.
  - A write of 0 pulses valid but does not set done.
  - Writes after done update tohost_data_o only.
  - TOHOST reads return tohost_data_o.
- CONSOLE write with be[0]=1: in t+1 console_valid_o=1 and console_char_o=wdata[7:0].
- CONSOLE reads return 0, err=0.
- Host MMIO writes behave the same as core MMIO writes.
- Internal state: last_grant, registered response owner/valid/decode, tohost/done/pass/console registers. No other state.

Test Plan:
- Reset: assert reset for 3 cycles with both reqs high -> no gnt/rvalid/mem_req; all outputs 0.
- Core write then read: write 32'hDEADBEEF to 0x80000010 (be=F), then read it -> mem_addr_o=4 both times; c_rvalid_o one cycle after each grant; read returns DEADBEEF, err=0.
- Contention: both req held for 6 cycles to distinct dmem addresses -> gnt order C,H,C,H,C,H; each rvalid goes to the correct port one cycle after its grant; no cycle has two gnts.
- Tohost: core writes 0, then 1, then 5 to 0x80001000 -> three tohost_valid pulses; sim_done_o set after the second write with sim_pass_o=1; both unchanged after the 5 write; tohost_data_o=5.
- Console/err: host writes 0x41 be=1 to 0x9a100000 -> console_valid_o pulse with char 'A', mem_req_o=0; core reads 0x10000000 -> rvalid, err=1, rdata=0.
- Reset mid-operation: grant a read in cycle t, assert reset in t+1 -> no rvalid; outputs 0; first conflict after reset goes to the core.

Source files
------------

// File: rtl/zeroriscy_dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data SRAM between the core LSU and a host port.
// Also decodes the tohost status word and the console character register.
module zeroriscy_dmem_arbiter #(
    parameter int unsigned MEM_AW       = 15,
    parameter logic [31:0] DMEM_BASE    = 32'h80000000,
    parameter logic [31:0] TOHOST_ADDR  = 32'h80001000,
    parameter logic [31:0] CONSOLE_ADDR = 32'h9a100000
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              c_req_i,
    input  logic              c_we_i,
    input  logic [3:0]        c_be_i,
    input  logic [31:0]       c_addr_i,
    input  logic [31:0]       c_wdata_i,
    output logic              c_gnt_o,
    output logic              c_rvalid_o,
    output logic [31:0]       c_rdata_o,
    output logic              c_err_o,

    input  logic              h_req_i,
    input  logic              h_we_i,
    input  logic [3:0]        h_be_i,
    input  logic [31:0]       h_addr_i,
    input  logic [31:0]       h_wdata_i,
    output logic              h_gnt_o,
    output logic              h_rvalid_o,
    output logic [31:0]       h_rdata_o,
    output logic              h_err_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,

    output logic              tohost_valid_o,
    output logic [31:0]       tohost_data_o,
    output logic              sim_done_o,
    output logic              sim_pass_o,
    output logic              console_valid_o,
    output logic [7:0]        console_char_o
);

    typedef enum logic [1:0] {
        DEC_DMEM    = 2'd0,
        DEC_TOHOST  = 2'd1,
        DEC_CONSOLE = 2'd2,
        DEC_ERR     = 2'd3
    } dec_e;

    // Port index 0 is the core, 1 is the host.
    localparam logic PORT_HOST = 1'b1;

    logic [1:0]        req_vec;
    logic [1:0]        we_vec;
    logic [1:0][3:0]   be_vec;
    logic [1:0][31:0]  addr_vec;
    logic [1:0][31:0]  wdata_vec;
    logic [1:0]        gnt_vec;
    logic [1:0]        rvalid_vec;
    logic [1:0]        err_vec;
    logic [1:0][31:0]  rdata_vec;

    logic              last_grant_reg, last_grant_next;
    logic              rsp_valid_reg;
    logic              rsp_owner_reg;
    dec_e              rsp_dec_reg;
    logic              rsp_we_reg;
    logic              tohost_valid_reg;
    logic [31:0]       tohost_data_reg;
    logic              sim_done_reg;
    logic              sim_pass_reg;
    logic              console_valid_reg;
    logic [7:0]        console_char_reg;

    logic              any_gnt;
    logic              sel;
    logic              sel_we;
    logic [3:0]        sel_be;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_wdata;
    dec_e              sel_dec;
    logic              tohost_wr;
    logic              console_wr;
    logic [31:0]       rsp_data;
    logic [1:0]        unused_addr_lsb;

    assign req_vec   = {h_req_i,   c_req_i};
    assign we_vec    = {h_we_i,    c_we_i};
    assign be_vec    = {h_be_i,    c_be_i};
    assign addr_vec  = {h_addr_i,  c_addr_i};
    assign wdata_vec = {h_wdata_i, c_wdata_i};

    // On a conflict the port that did not win the previous conflict goes first.
    always_comb begin
        gnt_vec         = 2'b00;
        last_grant_next = last_grant_reg;
        if (!reset) begin
            if (&req_vec) begin
                gnt_vec         = (last_grant_reg == PORT_HOST) ? 2'b01 : 2'b10;
                last_grant_next = (last_grant_reg == PORT_HOST) ? 1'b0 : 1'b1;
            end else begin
                gnt_vec = req_vec;
            end
        end
    end

    assign any_gnt   = |gnt_vec;
    assign sel       = gnt_vec[1];
    assign sel_we    = we_vec[sel];
    assign sel_be    = be_vec[sel];
    assign sel_addr  = addr_vec[sel];
    assign sel_wdata = wdata_vec[sel];
    assign unused_addr_lsb = sel_addr[1:0];

    // tohost sits inside the dmem window, so it is matched first.
    always_comb begin
        sel_dec = DEC_ERR;
        if (sel_addr[31:2] == TOHOST_ADDR[31:2]) begin
            sel_dec = DEC_TOHOST;
        end else if (sel_addr[31:2] == CONSOLE_ADDR[31:2]) begin
            sel_dec = DEC_CONSOLE;
        end else if (sel_addr[31:MEM_AW+2] == DMEM_BASE[31:MEM_AW+2]) begin
            sel_dec = DEC_DMEM;
        end
    end

    assign mem_req_o   = any_gnt && (sel_dec == DEC_DMEM);
    assign mem_we_o    = mem_req_o && sel_we;
    assign mem_be_o    = mem_req_o ? sel_be : 4'b0000;
    assign mem_addr_o  = mem_req_o ? sel_addr[MEM_AW+1:2] : '0;
    assign mem_wdata_o = mem_req_o ? sel_wdata : 32'h0;

    assign tohost_wr  = any_gnt && sel_we && (sel_dec == DEC_TOHOST);
    assign console_wr = any_gnt && sel_we && (sel_dec == DEC_CONSOLE) && sel_be[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_reg    <= PORT_HOST;
            rsp_valid_reg     <= 1'b0;
            rsp_owner_reg     <= 1'b0;
            rsp_dec_reg       <= DEC_DMEM;
            rsp_we_reg        <= 1'b0;
            tohost_valid_reg  <= 1'b0;
            tohost_data_reg   <= 32'h0;
            sim_done_reg      <= 1'b0;
            sim_pass_reg      <= 1'b0;
            console_valid_reg <= 1'b0;
            console_char_reg  <= 8'h00;
        end else begin
            last_grant_reg    <= last_grant_next;
            rsp_valid_reg     <= any_gnt;
            rsp_owner_reg     <= sel;
            rsp_dec_reg       <= sel_dec;
            rsp_we_reg        <= sel_we;
            tohost_valid_reg  <= tohost_wr;
            console_valid_reg <= console_wr;
            if (tohost_wr) begin
                tohost_data_reg <= sel_wdata;
                // Only the first nonzero value decides the test outcome.
                if (!sim_done_reg && (sel_wdata != 32'h0)) begin
                    sim_done_reg <= 1'b1;
                    sim_pass_reg <= (sel_wdata == 32'h1);
                end
            end
            if (console_wr) begin
                console_char_reg <= sel_wdata[7:0];
            end
        end
    end

    always_comb begin
        rsp_data = 32'h0;
        if (!rsp_we_reg) begin
            case (rsp_dec_reg)
                DEC_DMEM:   rsp_data = mem_rdata_i;
                DEC_TOHOST: rsp_data = tohost_data_reg;
                default:    rsp_data = 32'h0;
            endcase
        end
    end

    // A response still in flight when reset rises is suppressed.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
            assign rvalid_vec[gi] = !reset && rsp_valid_reg && (rsp_owner_reg == 1'(gi));
            assign rdata_vec[gi]  = rvalid_vec[gi] ? rsp_data : 32'h0;
            assign err_vec[gi]    = rvalid_vec[gi] && (rsp_dec_reg == DEC_ERR);
        end
    endgenerate

    assign c_gnt_o    = gnt_vec[0];
    assign h_gnt_o    = gnt_vec[1];
    assign c_rvalid_o = rvalid_vec[0];
    assign h_rvalid_o = rvalid_vec[1];
    assign c_rdata_o  = rdata_vec[0];
    assign h_rdata_o  = rdata_vec[1];
    assign c_err_o    = err_vec[0];
    assign h_err_o    = err_vec[1];

    assign tohost_valid_o  = !reset && tohost_valid_reg;
    assign tohost_data_o   = reset ? 32'h0 : tohost_data_reg;
    assign sim_done_o      = !reset && sim_done_reg;
    assign sim_pass_o      = !reset && sim_pass_reg;
    assign console_valid_o = !reset && console_valid_reg;
    assign console_char_o  = reset ? 8'h00 : console_char_reg;

endmodule

// File: tb/tb_zeroriscy_dmem_arbiter.sv
// Directed bench for zeroriscy_dmem_arbiter with a small behavioural SRAM attached.
// Inputs change 1ns after the rising edge; outputs are sampled 1-2ns after it.
module tb_zeroriscy_dmem_arbiter;

    localparam int MEM_AW = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              c_req_i, c_we_i, h_req_i, h_we_i;
    logic [3:0]        c_be_i, h_be_i;
    logic [31:0]       c_addr_i, c_wdata_i, h_addr_i, h_wdata_i;
    logic              c_gnt_o, c_rvalid_o, c_err_o, h_gnt_o, h_rvalid_o, h_err_o;
    logic [31:0]       c_rdata_o, h_rdata_o;
    logic              mem_req_o, mem_we_o;
    logic [3:0]        mem_be_o;
    logic [MEM_AW-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o, mem_rdata_i;
    logic              tohost_valid_o, sim_done_o, sim_pass_o, console_valid_o;
    logic [31:0]       tohost_data_o;
    logic [7:0]        console_char_o;

    int checks = 0;
    int failures = 0;

    logic [31:0] tb_mem [128];

    always #5 clk = ~clk;

    zeroriscy_dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .c_req_i(c_req_i), .c_we_i(c_we_i), .c_be_i(c_be_i), .c_addr_i(c_addr_i),
        .c_wdata_i(c_wdata_i), .c_gnt_o(c_gnt_o), .c_rvalid_o(c_rvalid_o),
        .c_rdata_o(c_rdata_o), .c_err_o(c_err_o),
        .h_req_i(h_req_i), .h_we_i(h_we_i), .h_be_i(h_be_i), .h_addr_i(h_addr_i),
        .h_wdata_i(h_wdata_i), .h_gnt_o(h_gnt_o), .h_rvalid_o(h_rvalid_o),
        .h_rdata_o(h_rdata_o), .h_err_o(h_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .tohost_valid_o(tohost_valid_o), .tohost_data_o(tohost_data_o),
        .sim_done_o(sim_done_o), .sim_pass_o(sim_pass_o),
        .console_valid_o(console_valid_o), .console_char_o(console_char_o)
    );

    // SRAM model: preloaded with word i = 0x1000_0000 + i, one-cycle read latency.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 128; i++) tb_mem[i] <= 32'h10000000 + 32'(i);
            mem_rdata_i <= 32'h0;
        end else if (mem_req_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) tb_mem[mem_addr_o[6:0]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end
            mem_rdata_i <= tb_mem[mem_addr_o[6:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_c(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
        c_req_i = req; c_we_i = we; c_be_i = be; c_addr_i = addr; c_wdata_i = wdata;
    endtask

    task automatic drv_h(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
        h_req_i = req; h_we_i = we; h_be_i = be; h_addr_i = addr; h_wdata_i = wdata;
    endtask

    initial begin
        reset = 1'b1;
        drv_c(1'b1, 1'b0, 4'hF, 32'h80000040, 32'h0);
        drv_h(1'b1, 1'b0, 4'hF, 32'h80000080, 32'h0);

        // Reset held three cycles with both ports requesting.
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            chk("rst_c_gnt", 32'(c_gnt_o), 32'd0);
            chk("rst_h_gnt", 32'(h_gnt_o), 32'd0);
            chk("rst_mem_req", 32'(mem_req_o), 32'd0);
            chk("rst_rvalid", {30'd0, h_rvalid_o, c_rvalid_o}, 32'd0);
        end
        chk("rst_flags", {27'd0, tohost_valid_o, sim_done_o, sim_pass_o, console_valid_o, c_err_o}, 32'd0);
        chk("rst_tohost_data", tohost_data_o, 32'd0);
        reset = 1'b0;
        drv_c(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drv_h(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        // Core write then back-to-back read of 0x80000010 (word 4).
        tick();
        drv_c(1'b1, 1'b1, 4'hF, 32'h80000010, 32'hDEADBEEF);
        #1;
        chk("wr_c_gnt", 32'(c_gnt_o), 32'd1);
        chk("wr_mem_req_we", {30'd0, mem_req_o, mem_we_o}, 32'd3);
        chk("wr_mem_addr", 32'(mem_addr_o), 32'd4);
        chk("wr_mem_wdata", mem_wdata_o, 32'hDEADBEEF);
        tick();
        chk("wr_c_rvalid", 32'(c_rvalid_o), 32'd1);
        chk("wr_c_err", 32'(c_err_o), 32'd0);
        drv_c(1'b1, 1'b0, 4'hF, 32'h80000010, 32'h0);
        #1;
        chk("rd_c_gnt", 32'(c_gnt_o), 32'd1);
        chk("rd_mem_addr", 32'(mem_addr_o), 32'd4);
        chk("rd_mem_we", 32'(mem_we_o), 32'd0);
        tick();
        drv_c(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("rd_c_rvalid", 32'(c_rvalid_o), 32'd1);
        chk("rd_c_rdata", c_rdata_o, 32'hDEADBEEF);
        chk("rd_c_err", 32'(c_err_o), 32'd0);
        chk("rd_h_rvalid", 32'(h_rvalid_o), 32'd0);
        tick();
        chk("idle_c_rvalid", 32'(c_rvalid_o), 32'd0);

        // Six cycles of contention: core reads word 16, host reads word 32.
        drv_c(1'b1, 1'b0, 4'hF, 32'h80000040, 32'h0);
        drv_h(1'b1, 1'b0, 4'hF, 32'h80000080, 32'h0);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                chk("cont_c_rvalid", 32'(c_rvalid_o), (k % 2 == 1) ? 32'd1 : 32'd0);
                chk("cont_h_rvalid", 32'(h_rvalid_o), (k % 2 == 0) ? 32'd1 : 32'd0);
                chk("cont_rdata", c_rdata_o | h_rdata_o, (k % 2 == 1) ? 32'h10000010 : 32'h10000020);
            end
            #1;
            chk("cont_c_gnt", 32'(c_gnt_o), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("cont_h_gnt", 32'(h_gnt_o), (k % 2 == 1) ? 32'd1 : 32'd0);
            tick();
        end
        drv_c(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drv_h(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("cont_last_h_rvalid", 32'(h_rvalid_o), 32'd1);
        chk("cont_last_h_rdata", h_rdata_o, 32'h10000020);
        chk("cont_last_c_rvalid", 32'(c_rvalid_o), 32'd0);

        // tohost writes 0, 1, 5 back to back, then a read.
        tick();
        drv_c(1'b1, 1'b1, 4'hF, 32'h80001000, 32'd0);
        #1;
        chk("th0_gnt", 32'(c_gnt_o), 32'd1);
        chk("th0_mem_req", 32'(mem_req_o), 32'd0);
        tick();
        chk("th0_valid", 32'(tohost_valid_o), 32'd1);
        chk("th0_data", tohost_data_o, 32'd0);
        chk("th0_done", 32'(sim_done_o), 32'd0);
        chk("th0_rsp", {30'd0, c_rvalid_o, c_err_o}, 32'd2);
        drv_c(1'b1, 1'b1, 4'hF, 32'h80001000, 32'd1);
        tick();
        chk("th1_valid", 32'(tohost_valid_o), 32'd1);
        chk("th1_data", tohost_data_o, 32'd1);
        chk("th1_done_pass", {30'd0, sim_done_o, sim_pass_o}, 32'd3);
        drv_c(1'b1, 1'b1, 4'hF, 32'h80001000, 32'd5);
        tick();
        chk("th5_valid", 32'(tohost_valid_o), 32'd1);
        chk("th5_data", tohost_data_o, 32'd5);
        chk("th5_done_pass", {30'd0, sim_done_o, sim_pass_o}, 32'd3);
        drv_c(1'b1, 1'b0, 4'hF, 32'h80001000, 32'd0);
        tick();
        drv_c(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("thrd_valid", 32'(tohost_valid_o), 32'd0);
        chk("thrd_rdata", c_rdata_o, 32'd5);
        chk("thrd_rvalid", 32'(c_rvalid_o), 32'd1);

        // Host console writes, then a core read of an unmapped address.
        drv_h(1'b1, 1'b1, 4'h1, 32'h9a100000, 32'h00000041);
        #1;
        chk("con_h_gnt", 32'(h_gnt_o), 32'd1);
        chk("con_mem_req", 32'(mem_req_o), 32'd0);
        tick();
        chk("con_valid", 32'(console_valid_o), 32'd1);
        chk("con_char", 32'(console_char_o), 32'h41);
        chk("con_h_rsp", {30'd0, h_rvalid_o, h_err_o}, 32'd2);
        chk("con_c_rvalid", 32'(c_rvalid_o), 32'd0);
        drv_h(1'b1, 1'b1, 4'h2, 32'h9a100000, 32'h00004242);
        tick();
        drv_h(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("con_be2_valid", 32'(console_valid_o), 32'd0);
        drv_c(1'b1, 1'b0, 4'hF, 32'h10000000, 32'h0);
        #1;
        chk("err_c_gnt", 32'(c_gnt_o), 32'd1);
        chk("err_mem_req", 32'(mem_req_o), 32'd0);
        tick();
        drv_c(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("err_c_rsp", {30'd0, c_rvalid_o, c_err_o}, 32'd3);
        chk("err_c_rdata", c_rdata_o, 32'd0);

        // Reset arrives while a read response is pending.
        tick();
        drv_c(1'b1, 1'b0, 4'hF, 32'h80000040, 32'h0);
        #1;
        chk("mid_c_gnt", 32'(c_gnt_o), 32'd1);
        tick();
        reset = 1'b1;
        drv_c(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("mid_rvalid", {30'd0, h_rvalid_o, c_rvalid_o}, 32'd0);
        chk("mid_done", 32'(sim_done_o), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("post_rvalid", 32'(c_rvalid_o), 32'd0);
        chk("post_flags", {30'd0, sim_done_o, sim_pass_o}, 32'd0);
        chk("post_tohost_data", tohost_data_o, 32'd0);
        chk("post_console_char", 32'(console_char_o), 32'd0);
        drv_c(1'b1, 1'b0, 4'hF, 32'h80000040, 32'h0);
        drv_h(1'b1, 1'b0, 4'hF, 32'h80000080, 32'h0);
        #1;
        chk("post_first_c_gnt", 32'(c_gnt_o), 32'd1);
        chk("post_first_h_gnt", 32'(h_gnt_o), 32'd0);
        tick();
        #1;
        chk("post_second_h_gnt", 32'(h_gnt_o), 32'd1);
        chk("post_second_c_gnt", 32'(c_gnt_o), 32'd0);
        chk("post_c_rdata", c_rdata_o, 32'h10000010);
        drv_c(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drv_h(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
